// File: rtl/seq_det_pkg.sv
// Shared defaults and types for the serial pattern detector and its lock tracker.
package seq_det_pkg;

  localparam int unsigned DEFAULT_PAT_W   = 4;
  localparam logic [3:0]  DEFAULT_PATTERN = 4'b1011;
  localparam int unsigned DEFAULT_CNT_W   = 8;
  localparam int unsigned DEFAULT_LOCK_N  = 3;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/pattern_lock_tracker.sv
// Periodic-lock tracker: asserts locked after LOCK_N matches spaced exactly PAT_W
// accepted bits apart; drops lock when PAT_W bits pass without a match.
module pattern_lock_tracker
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W  = DEFAULT_PAT_W,
  parameter int unsigned LOCK_N = DEFAULT_LOCK_N
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic match_now,
  output logic locked
);

  localparam int unsigned GAP_W = $clog2(PAT_W + 2);
  localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(PAT_W + 1);
  localparam logic [GAP_W-1:0] GAP_PERIOD = GAP_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOST   = GAP_W'(PAT_W);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(LOCK_N);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic [RUN_W-1:0] run_q, run_d;
  lock_state_t      state_q, state_d;

  always_comb begin
    gap_d   = gap_q;
    run_d   = run_q;
    state_d = state_q;
    if (bit_valid) begin
      if (match_now) begin
        gap_d = '0;
        // gap==PAT_W-1 before this bit means the match lands exactly PAT_W bits later
        if (gap_q == GAP_PERIOD) begin
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        end else begin
          run_d = RUN_W'(1);
        end
        state_d = (run_d == RUN_MAX) ? LOCKED : TRACKING;
      end else begin
        if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
        if (gap_d == GAP_LOST) begin
          run_d   = '0;
          state_d = UNLOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q   <= '0;
      run_q   <= '0;
      state_q <= UNLOCKED;
    end else begin
      gap_q   <= gap_d;
      run_q   <= run_d;
      state_q <= state_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: rtl/serial_pattern_detector.sv
// Overlapping serial pattern detector with registered match pulse and saturating count.
// Define DET_LOCK_EN to build the periodic-lock tracker; otherwise locked is tied low.
module serial_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int unsigned      CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned      LOCK_N  = DEFAULT_LOCK_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             locked
);

  if (PAT_W < 2 || PAT_W > 16) begin : g_chk_pat_w
    $error("serial_pattern_detector: PAT_W must be in 2..16");
  end
  if (LOCK_N < 1) begin : g_chk_lock_n
    $error("serial_pattern_detector: LOCK_N must be at least 1");
  end

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PAT_W - 1);

  // The oldest history bit can never take part in a future match, so only
  // PAT_W-1 bits are stored; the incoming bit completes the window.
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [PAT_W-1:0]  window;

  assign window  = {hist_q, bit_in};
  assign match_d = bit_valid && (fill_q >= FILL_NEED) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (bit_valid) begin
      hist_d = window[HIST_W-1:0];
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (clear_cnt) begin
      match_cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && match_cnt_q != '1) begin
      match_cnt_d = match_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = match_cnt_q;

`ifdef DET_LOCK_EN
  pattern_lock_tracker #(
    .PAT_W  (PAT_W),
    .LOCK_N (LOCK_N)
  ) u_lock (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .match_now (match_d),
    .locked    (locked)
  );
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench: directed scenarios plus randomized stream against a queue-based model.
module tb_serial_pattern_detector;

  localparam int unsigned PAT_W  = 4;
  localparam logic [3:0]  PAT    = 4'b1011;
  localparam int unsigned LOCK_N = 3;
  localparam int          CAP1   = 255;
  localparam int          CAP2   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       clear_cnt = 1'b0;
  logic       match, match2, locked, locked2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_total = 0;
  int n_bad   = 0;
  bit started = 1'b0;
  int ph      = 0;

  // model state
  bit hist[$];
  bit m_match = 1'b0;
  bit m_hit;
  int m_cnt = 0, m_cnt2 = 0;
  int m_acc = 0, m_last = 0, m_run = 0;
  bit m_locked = 1'b0;

  always #5 clk = ~clk;

  serial_pattern_detector u_dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear_cnt (clear_cnt),
    .match     (match),
    .match_cnt (match_cnt),
    .locked    (locked)
  );

  serial_pattern_detector #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear_cnt (clear_cnt),
    .match     (match2),
    .match_cnt (match_cnt2),
    .locked    (locked2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: last PAT_W accepted bits in a queue; lock from match positions in the accepted-bit index.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_match = 1'b0; m_cnt = 0; m_cnt2 = 0;
      m_acc = 0; m_last = 0; m_run = 0; m_locked = 1'b0;
    end else begin
      m_hit = 1'b0;
      if (bit_valid) begin
        hist.push_back(bit_in);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        m_acc++;
        if (hist.size() == PAT_W) begin
          m_hit = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (hist[i] != PAT[PAT_W-1-i]) m_hit = 1'b0;
        end
        if (m_hit) begin
          if (m_acc - m_last == PAT_W) m_run = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
          else m_run = 1;
          m_last = m_acc;
          m_locked = (m_run >= LOCK_N);
        end else if (m_acc - m_last == PAT_W) begin
          m_run = 0;
          m_locked = 1'b0;
        end
      end
      m_match = m_hit;
      if (clear_cnt) begin
        m_cnt  = m_hit ? 1 : 0;
        m_cnt2 = m_hit ? 1 : 0;
      end else if (m_hit) begin
        if (m_cnt < CAP1) m_cnt++;
        if (m_cnt2 < CAP2) m_cnt2++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_match", match, m_match);
      chk("cyc_match2", match2, m_match);
      chk("cyc_cnt", match_cnt, m_cnt);
      chk("cyc_cnt2", match_cnt2, m_cnt2);
`ifdef DET_LOCK_EN
      chk("cyc_locked", locked, m_locked);
      chk("cyc_locked2", locked2, m_locked);
`else
      chk("cyc_locked", locked, 0);
      chk("cyc_locked2", locked2, 0);
`endif
    end
  end

  task automatic send(input logic b, input logic clr = 1'b0);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; clear_cnt = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0; clear_cnt = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bit_valid = 1'b0; clear_cnt = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  logic [11:0] e1;
  logic [6:0]  s2, e2;

  initial begin
    #2 reset = 1'b1;
    #1 started = 1'b1;
    #20;
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk); #2 reset = 1'b0;

    // 1011 repeated x3
    e1 = 12'b0001_0001_0001;
    for (int i = 0; i < 12; i++) begin
      send(PAT[3 - (i % 4)]);
      chk("t1_match", match, e1[11-i]);
`ifdef DET_LOCK_EN
      if (i == 7)  chk("t1_lock_b8", locked, 0);
      if (i == 11) chk("t1_lock_b12", locked, 1);
`endif
    end
    chk("t1_cnt", match_cnt, 3);
`ifdef DET_LOCK_EN
    send(1'b1); chk("t6_lock_1", locked, 1);
    send(1'b0); chk("t6_lock_2", locked, 1);
    send(1'b0); chk("t6_lock_3", locked, 1);
    send(1'b0); chk("t6_lock_4", locked, 0);
`endif

    // overlap 1011011
    pulse_reset();
    s2 = 7'b1011011; e2 = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send(s2[6-i]);
      chk("t2_match", match, e2[6-i]);
      chk("t2_lock", locked, 0);
    end
    chk("t2_cnt", match_cnt, 2);

    // idle gap before final bit
    pulse_reset();
    send(1'b1); send(1'b0); send(1'b1);
    chk("t3_pre", match, 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("t3_gap", match, 0);
    end
    send(1'b1); chk("t3_hit", match, 1);
    idle();     chk("t3_after", match, 0);
    chk("t3_cnt", match_cnt, 1);

    // reset straddling a partial pattern
    pulse_reset();
    send(1'b1); send(1'b0); send(1'b1);
    pulse_reset();
    send(1'b1); chk("t4_b1", match, 0);
    send(1'b0); chk("t4_b2", match, 0);
    send(1'b1); chk("t4_b3", match, 0);
    send(1'b1); chk("t4_b4", match, 1);

    // narrow counter saturation and clear-with-match
    pulse_reset();
    for (int i = 0; i < 20; i++) send(PAT[3 - (i % 4)]);
    chk("t5_cnt2_sat", match_cnt2, 3);
    chk("t5_cnt", match_cnt, 5);
    send(1'b1); send(1'b0); send(1'b1);
    send(1'b1, 1'b1);
    chk("t5_clr_cnt2", match_cnt2, 1);
    chk("t5_clr_cnt", match_cnt, 1);
    send(1'b0, 1'b1);
    chk("t5_clr_only", match_cnt, 0);

    // full counter saturation
    pulse_reset();
    for (int i = 0; i < 1200; i++) send(PAT[3 - (i % 4)]);
    chk("t7_cnt_sat", match_cnt, 255);
    chk("t7_cnt2_sat", match_cnt2, 3);

    // randomized stream, partly biased toward the pattern
    pulse_reset();
    ph = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
        ph = 0;
      end
      @(negedge clk);
      bit_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        bit_in = PAT[3 - ph];
        if (bit_valid) ph = (ph + 1) % 4;
      end else begin
        bit_in = 1'($urandom_range(0, 1));
      end
      clear_cnt = ($urandom_range(0, 31) == 0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
Consumes the serial bitstream from the 1011 sequence generator and detects a fixed bit pattern, default 1011, with overlap allowed.
- Produces a one-cycle match pulse and a saturating match count.
- Optionally asserts a lock flag once the pattern repeats with a stable period.
- Sits directly downstream of the generator. Used as its self-check and as a frame-alignment front end.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1011, pattern to detect; MSB is the first bit received
CNT_W, 8, width of the match counter
LOCK_N, 3, consecutive on-period matches needed to assert lock (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
bit_valid  input  1  bit_in is sampled at the posedge when high
bit_in  input  1  serial data bit
clear_cnt  input  1  synchronous clear of match_cnt
match  output  1  one-cycle pulse: pattern completed on the last accepted bit
match_cnt  output  CNT_W  saturating count of matches
locked  output  1  periodic-lock flag (optional feature)

Behaviour:
- Reset state: history=0, fill=0, match=0, match_cnt=0, locked=0, gap=0, run=0.
- History shift register (PAT_W bits):
  - On bit_valid, shift in: history <= {history[PAT_W-2:0], bit_in}.
  - fill counter tracks bits received, saturating at PAT_W.
  - When bit_valid=0, nothing changes.
- Match condition: bit_valid && fill >= PAT_W-1 && {history[PAT_W-2:0], bit_in} == PATTERN.
- Match latency: match is registered. It goes high on the edge that accepts the completing bit and stays high exactly one cycle. It is 0 whenever the current cycle's condition is false.
- Overlap: the history is never flushed on a match. For 1011011, matches occur on bits 4 and 7.
- match_cnt:
  - Increments on the same edge match rises.
  - Saturates at 2^CNT_W-1 with no wrap.
  - If clear_cnt and a match occur in the same cycle, the result is 1.
  - If clear_cnt occurs alone, the result is 0.
- Reset mid-stream: all state is cleared. A partial pattern straddling reset is never detected; PAT_W fresh bits are required.
- bit_valid gaps: idle cycles between valid bits do not affect detection. Only accepted bits count.

Optional Feature:
Macro DET_LOCK_EN.
- Defined:
  - gap counts accepted bits since the last match, saturating at PAT_W+1.
  - A match with gap==PAT_W-1 (exactly PAT_W bits after the previous match) increments run, saturating at LOCK_N. Any other match sets run=1.
  - locked=1 when run reaches LOCK_N; it updates on the same edge as the match that reaches LOCK_N.
  - If gap reaches PAT_W without a match, run=0 and locked=0 on that edge.
  - Reset clears gap, run and locked.
- Undefined: locked is tied to 0 and no gap/run logic is built.

Decomposition:
- Package seq_det_pkg holds:
  - DEFAULT_PAT_W=4, DEFAULT_PATTERN=4'b1011, DEFAULT_CNT_W=8, DEFAULT_LOCK_N=3
  - lock_state typedef: UNLOCKED, TRACKING, LOCKED, used for debug visibility.
- Sub-module pattern_lock_tracker holds the gap/run/locked logic. Inputs: clk, reset, bit_valid, match_now. Output: locked. It is instantiated only under DET_LOCK_EN.

Test Plan:
- Reset, then drive the generator stream 1,0,1,1 repeating with bit_valid=1 for 12 bits -> match pulses after bits 4, 8, 12; match_cnt=3. With DET_LOCK_EN, locked=1 from the bit-12 edge.
- Drive 1,0,1,1,0,1,1 -> match after bits 4 and 7 (overlap); match_cnt=2. With DET_LOCK_EN, locked stays 0 (spacing 3).
- Drive 1,0,1 with 5 idle cycles (bit_valid=0) before the final 1 -> single match one cycle after the final bit is accepted; no spurious pulses during the gap.
- Drive 1,0,1, assert reset for one cycle, then drive 1 -> no match. Then drive 0,1,1 -> match after the fourth post-reset bit.
- CNT_W=2; drive 5 back-to-back patterns -> match_cnt holds at 3. Then pulse clear_cnt in the same cycle as a match -> match_cnt=1.
- DET_LOCK_EN: after lock, drive 1,0,0,0 -> locked=0 on the edge of the 4th bit past the last match; run=0.
